// File: rtl/ps_tx_pkg.sv
// Shared types and constants for the parallel-to-serial TX scheduler.
// State encoding, default frame geometry and a counter-width helper.
package ps_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } ps_state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_GAP   = 2;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping modulo N_REQ. valid_o is low when no request is pending.
module rr_arbiter
    import ps_tx_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDW  = cnt_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [IDW-1:0]   win_o,
    output logic             valid_o
);

    int idx;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_i[idx]) begin
                win_o   = IDW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps_tx_scheduler.sv
// Round-robin scheduler sharing one serializer among N_REQ requesters.
// Optional statistics outputs (FRAME_CNT, OVERLAP) when PS_TX_STATS_EN is defined.
module ps_tx_scheduler
    import ps_tx_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    localparam int IDW  = cnt_width(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA_IN,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       P_IN,
    output logic                   S_START,
    output logic                   BUSY,
    output logic [IDW-1:0]         CUR_ID,
`ifdef PS_TX_STATS_EN
    output logic [15:0]            FRAME_CNT,
    output logic [N_REQ-1:0]       OVERLAP,
`endif
    output ps_state_e              DBG_STATE
);

    localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

    ps_state_e        state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [WIDTH-1:0] p_in_q, p_in_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IDW-1:0]   arb_win;
    logic             arb_valid;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .win_o   (arb_win),
        .valid_o (arb_valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cur_id_q <= '0;
            p_in_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            p_in_q   <= p_in_d;
            cnt_q    <= cnt_d;
        end
    end

    // Requests are only looked at in IDLE; the word is captured on the
    // arbitration edge and held until the next capture.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        p_in_d   = p_in_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    p_in_d   = DATA_IN[int'(arb_win)*WIDTH +: WIDTH];
                    cur_id_d = arb_win;
                    ptr_d    = (int'(arb_win) == N_REQ - 1) ? '0 : arb_win + IDW'(1);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = BIT_LAST;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        cnt_d   = GAP_LAST;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        GNT = '0;
        if (state_q == ST_LOAD) begin
            GNT[cur_id_q] = 1'b1;
        end
    end

    assign S_START   = (state_q == ST_LOAD);
    assign BUSY      = (state_q != ST_IDLE);
    assign P_IN      = p_in_q;
    assign CUR_ID    = cur_id_q;
    assign DBG_STATE = state_q;

`ifdef PS_TX_STATS_EN
    logic [15:0]      frame_cnt_q;
    logic [N_REQ-1:0] overlap_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            frame_cnt_q <= '0;
            overlap_q   <= '0;
        end else begin
            if (state_q == ST_SHIFT && cnt_q == '0 && frame_cnt_q != 16'hFFFF) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (state_q != ST_IDLE) begin
                overlap_q <= overlap_q | REQ;
            end
        end
    end

    assign FRAME_CNT = frame_cnt_q;
    assign OVERLAP   = overlap_q;
`endif

endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Directed bench for ps_tx_scheduler (N_REQ=4, WIDTH=32, GAP=2).
// Statistics checks are compiled in when PS_TX_STATS_EN is defined.
module tb_ps_tx_scheduler;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int PERIOD_CYC = 2 + W + 2;

    logic           CLK;
    logic           RESET;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] DATA_IN;
    logic [N-1:0]   GNT;
    logic [W-1:0]   P_IN;
    logic           S_START;
    logic           BUSY;
    logic [IDW-1:0] CUR_ID;
    logic [1:0]     dbg_state;
`ifdef PS_TX_STATS_EN
    logic [15:0]    FRAME_CNT;
    logic [N-1:0]   OVERLAP;
`endif

    logic [W-1:0]   words [N];
    logic [IDW-1:0] exp_q [$];

    int n_run  = 0;
    int n_fail = 0;

    ps_tx_scheduler #(.N_REQ(N), .WIDTH(W), .GAP(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .DATA_IN   (DATA_IN),
        .GNT       (GNT),
        .P_IN      (P_IN),
        .S_START   (S_START),
        .BUSY      (BUSY),
        .CUR_ID    (CUR_ID),
`ifdef PS_TX_STATS_EN
        .FRAME_CNT (FRAME_CNT),
        .OVERLAP   (OVERLAP),
`endif
        .DBG_STATE (dbg_state)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        REQ   = '0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Drives req from the current negedge, then checks every S_START against
    // the head of exp_q; each granted requester drops its bit right away.
    task automatic run_grants(input logic [N-1:0] req, input int n_exp);
        int cyc  = 0;
        int last = -1;
        int got  = 0;
        logic [IDW-1:0] id;
        logic [N-1:0]   onehot;
        REQ = req;
        while ((got < n_exp || BUSY) && cyc < 40 * n_exp + 40) begin
            @(negedge CLK);
            cyc++;
            if (S_START) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", 64'(GNT), 64'(0));
                    id = CUR_ID;
                end else begin
                    id = exp_q.pop_front();
                    onehot = 4'b0001 << id;
                    check_eq("gnt_onehot", 64'(GNT), 64'(onehot));
                    check_eq("cur_id", 64'(CUR_ID), 64'(id));
                    check_eq("p_in_word", 64'(P_IN), 64'(words[id]));
                end
                if (last >= 0) begin
                    check_eq("frame_period", 64'(cyc - last), 64'(PERIOD_CYC));
                end
                last = cyc;
                got++;
                REQ[id] = 1'b0;
            end
        end
        check_eq("grant_count", 64'(got), 64'(n_exp));
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int busy_cycles;
        int cyc;
        int bad_gnt;
        int bad_pin;

        words[0] = 32'hA5A5_0F0F;
        words[1] = 32'h1111_2222;
        words[2] = 32'h3C3C_C3C3;
        words[3] = 32'hDEAD_BEEF;
        DATA_IN  = {words[3], words[2], words[1], words[0]};
        REQ      = '0;
        RESET    = 1'b0;

        // Reset and idle
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (10) @(negedge CLK);
        check_eq("idle_gnt", 64'(GNT), 64'(0));
        check_eq("idle_p_in", 64'(P_IN), 64'(0));
        check_eq("idle_s_start", 64'(S_START), 64'(0));
        check_eq("idle_busy", 64'(BUSY), 64'(0));
        check_eq("idle_cur_id", 64'(CUR_ID), 64'(0));
        check_eq("idle_state", 64'(dbg_state), 64'(0));

        // Single request held for one IDLE cycle
        REQ = 4'b0001;
        @(negedge CLK);
        REQ = 4'b0000;
        check_eq("single_s_start", 64'(S_START), 64'(1));
        check_eq("single_gnt", 64'(GNT), 64'(4'b0001));
        check_eq("single_p_in", 64'(P_IN), 64'(32'hA5A5_0F0F));
        check_eq("single_cur_id", 64'(CUR_ID), 64'(0));
        busy_cycles = 0;
        cyc = 0;
        while (BUSY && cyc < 100) begin
            busy_cycles++;
            @(negedge CLK);
            cyc++;
        end
        check_eq("single_busy_len", 64'(busy_cycles), 64'(35));
        check_eq("single_back_idle", 64'(dbg_state), 64'(0));

        // Round-robin from a fresh pointer, then 1001 grants 0 then 3
        do_reset();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3};
        run_grants(4'b1111, 4);
        exp_q = {2'd0, 2'd3};
        run_grants(4'b1001, 2);

        // Wrap: pointer parked at 3, REQ=0101 must grant 0
        do_reset();
        exp_q = {2'd2};
        run_grants(4'b0100, 1);
        REQ = 4'b0101;
        @(negedge CLK);
        check_eq("wrap_gnt", 64'(GNT), 64'(4'b0001));
        check_eq("wrap_p_in", 64'(P_IN), 64'(words[0]));
        REQ[0] = 1'b0;
        repeat (10) @(negedge CLK);
        REQ[1] = 1'b1;
        bad_gnt = 0;
        bad_pin = 0;
        cyc = 0;
        while (BUSY && cyc < 100) begin
            if (GNT != '0) bad_gnt++;
            if (P_IN != words[0]) bad_pin++;
            @(negedge CLK);
            cyc++;
        end
        check_eq("ignore_req_in_frame", 64'(bad_gnt), 64'(0));
        check_eq("p_in_stable", 64'(bad_pin), 64'(0));
        exp_q = {2'd1, 2'd2};
        run_grants(4'b0110, 2);

        // Reset in the middle of SHIFT
        REQ = 4'b0001;
        @(negedge CLK);
        check_eq("mid_s_start", 64'(S_START), 64'(1));
        REQ = 4'b0000;
        repeat (11) @(negedge CLK);
        check_eq("mid_busy_before", 64'(BUSY), 64'(1));
        RESET = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(BUSY), 64'(0));
        check_eq("mid_rst_s_start", 64'(S_START), 64'(0));
        check_eq("mid_rst_p_in", 64'(P_IN), 64'(0));
        check_eq("mid_rst_gnt", 64'(GNT), 64'(0));
        @(negedge CLK);
        RESET = 1'b1;
        exp_q = {2'd1};
        run_grants(4'b0010, 1);

`ifdef PS_TX_STATS_EN
        // Frame counter and sticky overlap flags
        do_reset();
        exp_q = {2'd0, 2'd1, 2'd2};
        run_grants(4'b0111, 3);
        check_eq("frame_cnt", 64'(FRAME_CNT), 64'(3));
        check_eq("overlap", 64'(OVERLAP), 64'(4'b0110));
        repeat (5) @(negedge CLK);
        check_eq("overlap_sticky", 64'(OVERLAP), 64'(4'b0110));
        do_reset();
        @(negedge CLK);
        check_eq("frame_cnt_rst", 64'(FRAME_CNT), 64'(0));
        check_eq("overlap_rst", 64'(OVERLAP), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ps_tx_scheduler.md
Name: ps_tx_scheduler

Overview:
- Shares the single paralelo-a-serie serializer among N_REQ requesters, each offering one WIDTH-bit word per request.
- Round-robin arbitration; captures the winner's word, drives the serializer's P_IN/S_START, and holds off new frames until the current frame plus the inter-frame gap has elapsed.
- Sits in front of the serializer inside the converter top level, on the same CLK.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, word/frame length in bits; the serializer emits WIDTH bits, one per cycle, starting the cycle after S_START.
- GAP, 2, idle cycles enforced after each frame's last bit (0 allowed).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  N_REQ  per-requester request level.
- DATA_IN  in  N_REQ*WIDTH  word of requester i at [i*WIDTH +: WIDTH]; stable while REQ[i]=1.
- GNT  out  N_REQ  one-hot, 1-cycle pulse: word accepted.
- P_IN  out  WIDTH  word to serializer, registered.
- S_START  out  1  1-cycle pulse starting a serializer frame.
- BUSY  out  1  high from S_START through the end of GAP.
- CUR_ID  out  clog2(N_REQ)  index of the requester owning the current/last frame.

Behaviour:
- Reset (RESET=0, async): state IDLE; GNT=0, P_IN=0, S_START=0, BUSY=0, CUR_ID=0; RR pointer=0; counters=0.
- Reset mid-frame aborts the frame immediately. No GNT is re-issued, and the serializer is reset by the same line.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If REQ≠0 at a rising edge, the winner is the first set bit at or above the RR pointer, wrapping modulo N_REQ.
  - On that edge: P_IN←DATA_IN[winner], CUR_ID←winner, pointer←(winner+1) mod N_REQ, go to LOAD.
  - If REQ=0, stay in IDLE.
- LOAD (exactly 1 cycle): S_START=1, GNT[winner]=1, BUSY=1; bit counter←WIDTH-1; go to SHIFT.
- SHIFT (WIDTH cycles): BUSY=1; decrement the counter each cycle.
  - At counter=0: go to GAP if GAP>0, else go to IDLE.
- GAP (GAP cycles): BUSY=1; then go to IDLE.
- P_IN holds its value from capture until the next capture, and is stable for the whole frame.
- Latency: REQ high in IDLE → S_START on the next cycle.
- Frame period with continuous requests: 2+WIDTH+GAP cycles.
- Requester rules:
  - Hold REQ until GNT is seen.
  - Dropping REQ before capture withdraws the request with no side effect.
  - Dropping REQ in the LOAD cycle does not cancel the already-captured word.
  - The requester deasserts REQ, or presents its next word, the cycle after GNT.
- Changes to REQ or DATA_IN outside IDLE are ignored.
- Simultaneous requests are resolved solely by the RR pointer; there is no fixed priority.
- A single continuously requesting source gets back-to-back frames at the period above.
- Only one GNT bit is ever set; GNT and S_START always coincide.

Optional Feature:
- Macro: PS_TX_STATS_EN.
- Defined:
  - Adds output FRAME_CNT [15:0] and output OVERLAP [N_REQ-1:0].
  - FRAME_CNT counts completed frames (SHIFT→GAP/IDLE), saturates at 16'hFFFF, and clears on reset.
  - OVERLAP[i] is a sticky flag set when REQ[i] is high while the FSM is outside IDLE (a waiting requester), cleared on reset.
- Undefined: neither port exists; logic identical otherwise.

Decomposition:
- Shared package ps_tx_pkg:
  - state enum/localparams (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, GAP=2'd3);
  - default WIDTH/GAP constants;
  - clog2-based counter-width helper.
- Sub-module rr_arbiter (N_REQ): combinational round-robin pick from REQ and pointer, giving winner index and a valid flag. The pointer register stays in ps_tx_scheduler.

Test Plan:
- Reset/idle: RESET=0 then 1, REQ=0 for 10 cycles → all outputs 0, state IDLE.
- Single request: REQ=4'b0001, word0=32'hA5A5_0F0F, held 1 cycle in IDLE.
  - Next cycle: S_START=1, GNT=4'b0001, P_IN=32'hA5A5_0F0F, CUR_ID=0.
  - BUSY high for exactly 1+32+2 cycles.
- Round-robin: REQ=4'b1111 held, each requester releasing after its GNT.
  - GNT order 0,1,2,3, with S_START 36 cycles apart.
  - A subsequent REQ=4'b1001 grants 0 then 3.
- Wrap and ignore: pointer=3, REQ=4'b0101 → grant 0.
  - REQ[1] raised during SHIFT → not granted until the FSM returns to IDLE.
  - P_IN unchanged during SHIFT.
- Reset mid-frame: RESET=0 at SHIFT count 10.
  - Immediately BUSY=0, S_START=0, P_IN=0.
  - After release with REQ=4'b0010: grant 1 (pointer was reset to 0, bit1 is the first set).
- PS_TX_STATS_EN: 3 complete frames → FRAME_CNT=3.
  - REQ[2] high during a frame → OVERLAP[2]=1 and sticky until reset.
